// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: filters lock, holds all resets, then releases them in ascending order.
// Optional soft-request counter port soft_rst_cnt is built when RST_SEQ_CNT_EN is defined.
module rst_seq_ctrl #(
  parameter int unsigned N_STAGE   = 4,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned HOLD_CYC  = 32,
  parameter int unsigned REL_DLY   = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               lock_in,
  input  logic               soft_rst_req,
  output logic [N_STAGE-1:0] stage_rst,
  output logic               seq_done,
  output logic               seq_busy
`ifdef RST_SEQ_CNT_EN
  ,
  output logic [7:0]         soft_rst_cnt
`endif
);

  localparam int unsigned MAX_LH  = (LOCK_FILT > HOLD_CYC) ? LOCK_FILT : HOLD_CYC;
  localparam int unsigned CNT_MAX = (MAX_LH > REL_DLY) ? MAX_LH : REL_DLY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(N_STAGE + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGE - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [N_STAGE-1:0] r_stage_rst;
  logic               r_seq_done;
  logic               r_seq_busy;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [N_STAGE-1:0] w_stage_nxt;
  logic               w_done_nxt;
  logic               w_busy_nxt;
  logic               w_lock_lost;
  logic               w_soft_acc;

  // Global events only apply once lock has been qualified; lock loss outranks a soft request.
  assign w_lock_lost = (r_state != S_WAIT_LOCK) && !lock_in;
  assign w_soft_acc  = (r_state != S_WAIT_LOCK) && lock_in && soft_rst_req;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_stage_rst <= '1;
      r_seq_done  <= 1'b0;
      r_seq_busy  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_stage_rst <= w_stage_nxt;
      r_seq_done  <= w_done_nxt;
      r_seq_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stage_nxt = r_stage_rst;
    w_done_nxt  = r_seq_done;
    w_busy_nxt  = r_seq_busy;

    case (r_state)
      S_WAIT_LOCK: begin
        w_stage_nxt = '1;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        if (lock_in) begin
          if (r_cnt == LOCK_LAST) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (r_cnt == REL_LAST) begin
          // Thermometer release: shifting in a zero drops the lowest still-asserted stage.
          w_cnt_nxt   = '0;
          w_stage_nxt = r_stage_rst << 1;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_stage_nxt = '0;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_stage_nxt = '1;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_lock_lost) begin
      w_state_nxt = S_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_stage_nxt = '1;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_soft_acc) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_stage_nxt = '1;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = 1'b1;
    end
  end

  assign stage_rst = r_stage_rst;
  assign seq_done  = r_seq_done;
  assign seq_busy  = r_seq_busy;

`ifdef RST_SEQ_CNT_EN
  logic [7:0] r_soft_cnt;

  // Saturating count of accepted soft requests; survives lock loss.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_soft_cnt <= 8'd0;
    end else if (w_soft_acc && (r_soft_cnt != 8'hFF)) begin
      r_soft_cnt <= r_soft_cnt + 8'd1;
    end
  end

  assign soft_rst_cnt = r_soft_cnt;
`endif

  a_thermo: assert property (@(posedge clk_in) disable iff (rst_in)
    ((~r_stage_rst) & ((~r_stage_rst) + N_STAGE'(1))) == '0);
  a_done_clear: assert property (@(posedge clk_in) disable iff (rst_in)
    r_seq_done |-> (r_stage_rst == '0));
  a_busy_done: assert property (@(posedge clk_in) disable iff (rst_in)
    !(r_seq_busy && r_seq_done));

endmodule
